cpu_bus_responder: RTL and testbench
====================================

Name: cpu_bus_responder

Overview:
Memory-side responder for the 65C816 core's bus cycles. It accepts each address, bank and cycle type the CPU presents, runs a request/acknowledge handshake to the memory fabric, and inserts wait states for slow (Mega II / I/O) regions. It returns read data on D_IN and paces the CPU through its EN clock-enable.

Parameters:
SLOW_WAIT, 3, extra wait cycles before issuing a request to the slow region (0..255)
TIMEOUT, 15, max cycles in REQ awaiting MEM_ACK before the cycle is aborted (1..255)

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
ADDR  in  24  CPU address {bank, addr}; stable while EN=0
VDA  in  1  valid data address
VPA  in  1  valid program address
RWN  in  1  1=read, 0=write
D_OUT  in  8  CPU write data
EN  out  1  CPU clock enable; one-cycle pulse completes a bus cycle
D_IN  out  8  read data to CPU
MEM_REQ  out  1  request to memory fabric
MEM_WE  out  1  1=write request
MEM_ADDR  out  24  latched request address
MEM_WDATA  out  8  latched write data
MEM_RDATA  in  8  read data, valid with MEM_ACK
MEM_ACK  in  1  request complete
BUS_ERR  out  1  one-cycle pulse on timeout abort
SLOW  out  1  high while the current cycle targets the slow region

Behaviour:
- Reset (async, RST_N=0): state=ACCEPT; EN=0, D_IN=8'h00, MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, BUS_ERR=0, SLOW=0; counters cleared. Reset mid-cycle drops MEM_REQ immediately; no completion is signalled.
- All outputs are registered.
- FSM states: ACCEPT, WAITS, REQ, DONE.
- ACCEPT:
  - Latch MEM_ADDR<=ADDR, MEM_WE<=~RWN, MEM_WDATA<=D_OUT.
  - VDA|VPA=0 (internal cycle) -> DONE.
  - Slow region -> SLOW<=1; if SLOW_WAIT=0 go to REQ, else load the wait counter with SLOW_WAIT and go to WAITS.
  - Otherwise -> REQ with MEM_REQ<=1.
  - Slow region = bank 8'hE0 or 8'hE1, or (bank 8'h00/8'h01 and ADDR[15:12]=4'hC).
- WAITS: decrement the counter each clock; on reaching 1 assert MEM_REQ<=1 and go to REQ.
- REQ:
  - MEM_REQ held high; address, WE and write data stay stable until MEM_ACK.
  - On MEM_ACK: MEM_REQ<=0; if read, D_IN<=MEM_RDATA; go to DONE.
  - Timeout counter starts at 0 on REQ entry and increments each REQ clock without ACK. When it reaches TIMEOUT: MEM_REQ<=0, D_IN<=8'hFF (read) or unchanged (write), BUS_ERR<=1 for one clock, go to DONE.
  - MEM_ACK in the same clock the count hits TIMEOUT: ACK wins, no BUS_ERR.
- DONE: EN=1 for exactly this clock; SLOW<=0; next state ACCEPT. The CPU samples D_IN on this clock.
- Latency, counted as clocks from ACCEPT to the EN pulse inclusive:
  - internal cycle: 2
  - fast region with ACK on the first REQ clock: 3
  - slow region: 3+SLOW_WAIT, plus any extra ACK delay
- D_IN holds its value across write and internal cycles; it only changes on read completion or read timeout.
- MEM_ACK outside REQ is ignored.
- VPA-only and VDA-only cycles are both treated as memory accesses.
- EN never asserts on two consecutive clocks.

Test Plan:
- Internal cycle: VDA=VPA=0 after reset release -> EN high on the 2nd clock; MEM_REQ never asserted; D_IN stays 8'h00.
- Fast read: ADDR=24'h02_1234, RWN=1; MEM_ACK with RDATA=8'hA5 on the first REQ clock -> MEM_ADDR=24'h021234, MEM_WE=0; EN on the 3rd clock with D_IN=8'hA5.
- Slow write: ADDR=24'hE0_C030, RWN=0, D_OUT=8'h5A, SLOW_WAIT=3 -> SLOW=1; MEM_REQ rises 3 clocks after ACCEPT with MEM_WE=1, MEM_WDATA=8'h5A; EN after ACK; D_IN unchanged.
- Slow decode boundary: 24'h00_BFFF -> fast path; 24'h00_C000 and 24'h01_CFFF -> slow; 24'h02_C000 -> fast.
- Timeout: read 24'h03_0000 with no MEM_ACK, TIMEOUT=15 -> MEM_REQ drops after 15 REQ clocks; BUS_ERR pulse; EN next clock with D_IN=8'hFF. ACK on exactly the 15th REQ clock -> normal data, no BUS_ERR.
- Reset mid-REQ: deassert RST_N while MEM_REQ=1 -> all outputs return to reset values asynchronously; after release the FSM is in ACCEPT and no stale EN appears.

Source files
------------

// File: rtl/cpu_bus_responder_if.sv
// rtl/cpu_bus_responder_if.sv - CPU bus and memory fabric signal bundle for cpu_bus_responder
//
// Purpose: groups the 65C816 bus-cycle signals and the memory request/ack
// signals so the responder and its environment connect through one port.
// Ports (signals):
//   ADDR[23:0]   CPU address {bank, addr}        VDA / VPA  valid data / program address
//   RWN          1=read, 0=write                 D_OUT[7:0] CPU write data
//   EN           CPU clock enable pulse          D_IN[7:0]  read data to CPU
//   MEM_REQ      request to memory fabric        MEM_WE     1=write request
//   MEM_ADDR     latched request address         MEM_WDATA  latched write data
//   MEM_RDATA    read data, valid with MEM_ACK   MEM_ACK    request complete
//   BUS_ERR      timeout abort pulse             SLOW       current cycle targets slow region
// Modports: slave = responder view, master = CPU/memory environment view.

interface cpu_bus_responder_if;
    logic [23:0] ADDR;
    logic        VDA;
    logic        VPA;
    logic        RWN;
    logic [7:0]  D_OUT;
    logic        EN;
    logic [7:0]  D_IN;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [23:0] MEM_ADDR;
    logic [7:0]  MEM_WDATA;
    logic [7:0]  MEM_RDATA;
    logic        MEM_ACK;
    logic        BUS_ERR;
    logic        SLOW;

    modport slave (
        input  ADDR, VDA, VPA, RWN, D_OUT, MEM_RDATA, MEM_ACK,
        output EN, D_IN, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, BUS_ERR, SLOW
    );

    modport master (
        output ADDR, VDA, VPA, RWN, D_OUT, MEM_RDATA, MEM_ACK,
        input  EN, D_IN, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, BUS_ERR, SLOW
    );
endinterface

// File: rtl/cpu_bus_responder.sv
// rtl/cpu_bus_responder.sv - memory-side responder pacing 65C816 bus cycles
//
// Purpose: accepts each CPU bus cycle, runs a request/ack handshake to the
// memory fabric with wait states for the slow (Mega II / I/O) region and a
// REQ timeout, returns read data on D_IN and completes the cycle with an EN pulse.
// Ports:
//   CLK    system clock
//   RST_N  asynchronous active-low reset
//   bus    cpu_bus_responder_if.slave (CPU side: ADDR/VDA/VPA/RWN/D_OUT/EN/D_IN;
//          memory side: MEM_REQ/MEM_WE/MEM_ADDR/MEM_WDATA/MEM_RDATA/MEM_ACK;
//          status: BUS_ERR/SLOW)
// Parameters:
//   SLOW_WAIT  extra wait clocks before requesting the slow region (0..255)
//   TIMEOUT    REQ clocks without MEM_ACK before the cycle is aborted (1..255)

module cpu_bus_responder #(
    parameter int SLOW_WAIT = 3,
    parameter int TIMEOUT   = 15
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    cpu_bus_responder_if.slave   bus
);

    localparam logic [7:0] SLOW_WAIT_C = 8'(SLOW_WAIT);
    localparam logic [7:0] TIMEOUT_C   = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        WAITS  = 2'd1,
        REQ    = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [7:0]  to_cnt_q, to_cnt_d;
    logic        en_q, en_d;
    logic [7:0]  din_q, din_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [23:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        err_q, err_d;
    logic        slow_q, slow_d;

    logic [7:0]  bank;
    logic        is_slow;
    logic        is_mem;

    assign bank    = bus.ADDR[23:16];
    assign is_mem  = bus.VDA | bus.VPA;
    // Mega II / I/O: banks E0/E1 entirely, plus the $Cxxx page of banks 00/01.
    assign is_slow = (bank == 8'hE0) || (bank == 8'hE1) ||
                     (((bank == 8'h00) || (bank == 8'h01)) && (bus.ADDR[15:12] == 4'hC));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ACCEPT;
            wait_cnt_q <= 8'd0;
            to_cnt_q   <= 8'd0;
            en_q       <= 1'b0;
            din_q      <= 8'h00;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 24'd0;
            wdata_q    <= 8'h00;
            err_q      <= 1'b0;
            slow_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            to_cnt_q   <= to_cnt_d;
            en_q       <= en_d;
            din_q      <= din_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            slow_q     <= slow_d;
        end
    end

    // Every output is a register; en_d/err_d are set on the transition into
    // DONE so that EN (and BUS_ERR on abort) are high exactly while in DONE.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        to_cnt_d   = to_cnt_q;
        en_d       = 1'b0;
        din_d      = din_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = 1'b0;
        slow_d     = slow_q;

        case (state_q)
            ACCEPT: begin
                addr_d   = bus.ADDR;
                we_d     = ~bus.RWN;
                wdata_d  = bus.D_OUT;
                to_cnt_d = 8'd0;
                if (!is_mem) begin
                    state_d = DONE;
                    en_d    = 1'b1;
                end else if (is_slow) begin
                    slow_d = 1'b1;
                    if (SLOW_WAIT_C == 8'd0) begin
                        req_d   = 1'b1;
                        state_d = REQ;
                    end else begin
                        wait_cnt_d = SLOW_WAIT_C;
                        state_d    = WAITS;
                    end
                end else begin
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end

            WAITS: begin
                // Counter value n means n wait clocks remain including this one.
                wait_cnt_d = wait_cnt_q - 8'd1;
                if (wait_cnt_q == 8'd1) begin
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end

            REQ: begin
                if (bus.MEM_ACK) begin
                    // ACK takes priority over a timeout landing on the same clock.
                    req_d   = 1'b0;
                    if (!we_q) begin
                        din_d = bus.MEM_RDATA;
                    end
                    state_d = DONE;
                    en_d    = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                    if ((to_cnt_q + 8'd1) == TIMEOUT_C) begin
                        req_d   = 1'b0;
                        if (!we_q) begin
                            din_d = 8'hFF;
                        end
                        err_d   = 1'b1;
                        state_d = DONE;
                        en_d    = 1'b1;
                    end
                end
            end

            DONE: begin
                slow_d  = 1'b0;
                state_d = ACCEPT;
            end

            default: begin
                state_d = ACCEPT;
            end
        endcase
    end

    assign bus.EN        = en_q;
    assign bus.D_IN      = din_q;
    assign bus.MEM_REQ   = req_q;
    assign bus.MEM_WE    = we_q;
    assign bus.MEM_ADDR  = addr_q;
    assign bus.MEM_WDATA = wdata_q;
    assign bus.BUS_ERR   = err_q;
    assign bus.SLOW      = slow_q;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// tb/tb_cpu_bus_responder.sv - scoreboard bench for cpu_bus_responder

module tb_cpu_bus_responder;

    localparam int SW = 3;
    localparam int TO = 15;

    logic CLK;
    logic RST_N;

    cpu_bus_responder_if bus();

    cpu_bus_responder #(
        .SLOW_WAIT (SW),
        .TIMEOUT   (TO)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int          lat;
        logic [7:0]  din;
        logic        err;
        logic        slow;
        int          req_at;
        logic        mem;
        logic [23:0] addr;
        logic        we;
        logic [7:0]  wdata;
    } exp_t;

    exp_t       sb[$];
    int         vectors;
    int         miscompares;
    logic [7:0] model_din;
    logic       at_done;
    logic       stray_ack;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One CPU bus cycle. ack_at = REQ clock (1-based) on which memory acks; 0 = never.
    task automatic run_cycle(input logic [23:0] addr, input logic vda, input logic vpa,
                             input logic rwn, input logic [7:0] dout,
                             input int ack_at, input logic [7:0] rdata);
        exp_t        e;
        exp_t        o;
        logic [7:0]  bk;
        int          pre;
        int          rc;
        logic        ok;
        int          n;
        int          req_n;
        int          req_first;
        logic        done;
        logic        slow_at2;
        logic [23:0] ma;
        logic        mwe;
        logic [7:0]  mwd;

        bk     = addr[23:16];
        e.mem  = vda | vpa;
        e.slow = e.mem && ((bk == 8'hE0) || (bk == 8'hE1) ||
                 ((bk inside {8'h00, 8'h01}) && (addr[15:12] == 4'hC)));
        e.addr  = addr;
        e.we    = ~rwn;
        e.wdata = dout;
        if (!e.mem) begin
            e.lat    = 2;
            e.err    = 1'b0;
            e.req_at = 0;
        end else begin
            pre      = e.slow ? (1 + SW) : 1;
            ok       = (ack_at >= 1) && (ack_at <= TO);
            rc       = ok ? ack_at : TO;
            e.lat    = pre + rc + 1;
            e.req_at = pre + 1;
            e.err    = ~ok;
            if (rwn) model_din = ok ? rdata : 8'hFF;
        end
        e.din = model_din;
        sb.push_back(e);

        if (at_done) begin
            @(posedge CLK);
            #1;
        end
        check_val("en_low_in_accept", bus.EN, 1'b0);
        bus.ADDR  = addr;
        bus.VDA   = vda;
        bus.VPA   = vpa;
        bus.RWN   = rwn;
        bus.D_OUT = dout;
        bus.MEM_ACK = stray_ack;
        bus.MEM_RDATA = 8'h00;

        n = 1; req_n = 0; req_first = 0; done = 1'b0; slow_at2 = 1'b0;
        ma = '0; mwe = 1'b0; mwd = '0;
        while (!done && n < 200) begin
            @(posedge CLK);
            #1;
            n++;
            if (n == 2) slow_at2 = bus.SLOW;
            if (bus.MEM_REQ) begin
                req_n++;
                if (req_n == 1) begin
                    req_first = n;
                    ma  = bus.MEM_ADDR;
                    mwe = bus.MEM_WE;
                    mwd = bus.MEM_WDATA;
                end
                bus.MEM_ACK   = (req_n == ack_at);
                bus.MEM_RDATA = rdata;
            end else begin
                bus.MEM_ACK = stray_ack;
            end
            if (bus.EN) done = 1'b1;
        end
        bus.MEM_ACK = 1'b0;
        at_done = 1'b1;

        o = sb.pop_front();
        check_val("en_seen", done, 1'b1);
        if (done) begin
            check_val("latency", n, o.lat);
            check_val("d_in", bus.D_IN, o.din);
            check_val("bus_err", bus.BUS_ERR, o.err);
            check_val("slow", slow_at2, o.slow);
            check_val("req_start", req_first, o.req_at);
            if (o.mem) begin
                check_val("mem_addr", ma, o.addr);
                check_val("mem_we", mwe, o.we);
                if (o.we) check_val("mem_wdata", mwd, o.wdata);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  rb;
        logic [7:0]  banks [6];

        vectors = 0; miscompares = 0; model_din = 8'h00; at_done = 1'b0; stray_ack = 1'b0;
        RST_N = 1'b0;
        bus.ADDR = '0; bus.VDA = 1'b0; bus.VPA = 1'b0; bus.RWN = 1'b1; bus.D_OUT = '0;
        bus.MEM_RDATA = '0; bus.MEM_ACK = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_val("rst_en", bus.EN, 1'b0);
        check_val("rst_din", bus.D_IN, 8'h00);
        check_val("rst_req", bus.MEM_REQ, 1'b0);
        check_val("rst_we", bus.MEM_WE, 1'b0);
        check_val("rst_addr", bus.MEM_ADDR, 24'h0);
        check_val("rst_wdata", bus.MEM_WDATA, 8'h00);
        check_val("rst_err", bus.BUS_ERR, 1'b0);
        check_val("rst_slow", bus.SLOW, 1'b0);
        RST_N = 1'b1;

        // Internal cycle with a stray ACK that must be ignored.
        stray_ack = 1'b1;
        run_cycle(24'h00_0000, 1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h00);
        stray_ack = 1'b0;
        run_cycle(24'h02_1234, 1'b1, 1'b0, 1'b1, 8'h00, 1, 8'hA5);
        run_cycle(24'hE0_C030, 1'b1, 1'b0, 1'b0, 8'h5A, 1, 8'h00);
        run_cycle(24'h00_BFFF, 1'b1, 1'b0, 1'b1, 8'h00, 1, 8'h11);
        run_cycle(24'h00_C000, 1'b1, 1'b0, 1'b1, 8'h00, 2, 8'h22);
        run_cycle(24'h01_CFFF, 1'b1, 1'b0, 1'b0, 8'h77, 1, 8'h00);
        run_cycle(24'h02_C000, 1'b1, 1'b0, 1'b1, 8'h00, 3, 8'h33);
        run_cycle(24'hE1_0000, 1'b0, 1'b1, 1'b1, 8'h00, 1, 8'h44);
        run_cycle(24'h10_0000, 1'b1, 1'b0, 1'b1, 8'h00, 1, 8'h55);
        run_cycle(24'h03_0000, 1'b1, 1'b0, 1'b1, 8'h00, 0, 8'h00);
        run_cycle(24'h03_0000, 1'b1, 1'b0, 1'b1, 8'h00, TO, 8'h66);
        run_cycle(24'h04_0000, 1'b1, 1'b0, 1'b0, 8'h99, 0, 8'h00);
        run_cycle(24'h00_0000, 1'b0, 1'b0, 1'b0, 8'h12, 0, 8'h00);

        banks[0] = 8'h00; banks[1] = 8'h01; banks[2] = 8'h02;
        banks[3] = 8'hE0; banks[4] = 8'hE1; banks[5] = 8'h7F;
        for (int i = 0; i < 8; i++) begin
            rb = 8'($urandom);
            run_cycle({banks[$urandom_range(0, 5)], 16'($urandom)}, 1'b1, 1'($urandom),
                      1'($urandom), 8'($urandom), $urandom_range(1, 4), rb);
        end

        // Reset while a read sits in REQ with no ACK.
        @(posedge CLK);
        #1;
        bus.ADDR = 24'h03_0000; bus.VDA = 1'b1; bus.VPA = 1'b0; bus.RWN = 1'b1;
        bus.MEM_ACK = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_val("req_before_rst", bus.MEM_REQ, 1'b1);
        #2;
        RST_N = 1'b0;
        #1;
        check_val("arst_req", bus.MEM_REQ, 1'b0);
        check_val("arst_en", bus.EN, 1'b0);
        check_val("arst_din", bus.D_IN, 8'h00);
        check_val("arst_addr", bus.MEM_ADDR, 24'h0);
        check_val("arst_err", bus.BUS_ERR, 1'b0);
        model_din = 8'h00;
        @(posedge CLK);
        #1;
        check_val("rst_hold_en", bus.EN, 1'b0);
        RST_N = 1'b1;
        at_done = 1'b0;
        run_cycle(24'h00_0000, 1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h00);
        run_cycle(24'h02_0001, 1'b1, 1'b0, 1'b1, 8'h00, 1, 8'hC3);

        check_val("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
